// File: rtl/joy_serializer.sv
// rtl/joy_serializer.sv - responder end of the serial joystick link (optional JOY_DEBOUNCE_EN button debounce)
module joy_serializer #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [11:0] p1_btn,
    input  logic [11:0] p2_btn,
    input  logic        joy_clk,
    input  logic        joy_load,
    output logic        joy_data,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] load_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   load_s;
    logic                   clk_rise;

    logic [23:0] btn_meta;
    logic [23:0] btn_sync;
    logic [23:0] btn_clean;
    logic [11:0] p1c;
    logic [11:0] p2c;

    logic [24:0] slot_tab;
    logic [24:0] sreg;
    logic [4:0]  slot_cnt;
    logic        armed_q;
    logic        do_load;
    logic        do_shift;
    logic        frame_end;

    // Parameter sanity: SYNC_STAGES must be 2..3 and DEB_CYCLES positive; no hardware here.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3 || DEB_CYCLES < 1) begin : g_param_range
    end

    // Resynchronise the reader's shift clock and load strobe; load idles high, clock idles low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync  <= '0;
            load_sync <= '1;
            clk_prev  <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], joy_clk};
            load_sync <= {load_sync[SYNC_STAGES-2:0], joy_load};
            clk_prev  <= clk_s;
        end
    end

    assign clk_s    = clk_sync[SYNC_STAGES-1];
    assign load_s   = load_sync[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_prev;

    // Two-flop synchroniser on every button bit; released buttons read as 1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta <= '1;
            btn_sync <= '1;
        end else begin
            btn_meta <= {p2_btn, p1_btn};
            btn_sync <= btn_meta;
        end
    end

`ifdef JOY_DEBOUNCE_EN
    localparam int CW = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES);

    logic [CW-1:0] deb_cnt [24];
    logic [23:0]   btn_deb;

    // A bit's debounced value follows only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_deb <= '1;
            for (int i = 0; i < 24; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 24; i++) begin
                if (btn_sync[i] == btn_deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CW'(DEB_CYCLES - 1)) begin
                    btn_deb[i] <= btn_sync[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_clean = btn_deb;
`else
    assign btn_clean = btn_sync;
`endif

    assign p1c = btn_clean[11:0];
    assign p2c = btn_clean[23:12];

    // Bit 0 is the pad (slot 0); bit k holds slot k, so shifting right presents slots in order.
    assign slot_tab = {p1c[7], p1c[9], p1c[11], p1c[10],
                       p2c[7], p2c[9], p2c[11], p2c[10],
                       p2c[0], p2c[1], p2c[2], p2c[3], p2c[4], p2c[5], p2c[6], p2c[8],
                       p1c[0], p1c[1], p1c[2], p1c[3], p1c[4], p1c[5], p1c[6], p1c[8],
                       1'b1};

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath controls; a low load strobe beats everything, including a clock rise.
    always_comb begin
        state_d   = state_q;
        do_load   = 1'b0;
        do_shift  = 1'b0;
        frame_end = 1'b0;
        if (!load_s) begin
            state_d = LOAD;
            do_load = 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    if (armed_q) begin
                        state_d = SHIFT;
                    end
                end
                SHIFT: begin
                    if (clk_rise) begin
                        do_shift = 1'b1;
                        if (slot_cnt == 5'd24) begin
                            state_d   = DONE;
                            frame_end = 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = LOAD;
                end
            endcase
        end
    end

    // Shift register, slot counter, arm flag and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sreg       <= '1;
            slot_cnt   <= 5'd0;
            armed_q    <= 1'b0;
            joy_data   <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (do_load) begin
                sreg     <= slot_tab;
                slot_cnt <= 5'd0;
                armed_q  <= 1'b1;
            end else if (do_shift) begin
                sreg     <= {1'b1, sreg[24:1]};
                slot_cnt <= slot_cnt + 5'd1;
            end
            joy_data <= (state_q == SHIFT) ? sreg[0] : 1'b1;
        end
    end

endmodule
